noc_stream_bridge: RTL
======================

// Module: noc_stream_bridge
// PURPOSE
// - Generalised NoC endpoint bridge for packet-processing tiles.
// - Unpacks NoC flits into an internal packet stream and buffers it in a FIFO_DEPTH-deep FIFO.
// - Re-packs each packet onto the NoC, with per-packet round-robin destination and VC assignment.
// - Successor to the fixed single-engine tile wrapper: width, depth, VC count and destination list are all parameters.
// PARAMETERS
// - DATA_WIDTH  512              stream payload bits; must be a multiple of 8
// - NOC_WIDTH   600              NoC flit width
// - NUM_VC      2                number of NoC virtual channels; VC_W = $clog2(NUM_VC)
// - NOC_RADIX   16               number of NoC routers; DST_W = $clog2(NOC_RADIX)
// - FIFO_DEPTH  8                ingress FIFO entries; power of 2, >= 2
// - NUM_DEST    4                length of the destination list
// - DEST        '{12,13,14,15}   [DST_W-1:0] node IDs, visited round-robin
// PORTS
// - clk          in   1          clock
// - reset        in   1          asynchronous, active-high reset
// - i_data_in    in   NOC_WIDTH  flit from the NoC
// - i_valid_in   in   1          flit valid
// - i_ready_out  out  1          bridge can accept a flit
// - o_data_out   out  NOC_WIDTH  flit to the NoC
// - o_valid_out  out  1          output flit valid
// - o_ready_in   in   1          NoC accepts the output flit
// - o_pkt_cnt    out  32         packets forwarded (PKT_STATS_EN only)
// - o_drop_cnt   out  16         flits dropped (PKT_STATS_EN only)
// BEHAVIOUR
// - Flit layout (identical in and out), EW = $clog2(DATA_WIDTH/8):
//   - data = [DATA_WIDTH-1:0], sop = [DW], eop = [DW+1], empty = [DW+2 +: EW]
//   - head = [NOC_WIDTH-1], tail = [NOC_WIDTH-2]
//   - vc = [NOC_WIDTH-3 -: VC_W], dst = next DST_W bits downward; unused bits 0
//   - Elaboration error if the layout does not fit in NOC_WIDTH.
// - Input header fields are ignored; only sop/eop/empty/data are stored.
// - Reset: FIFO empty, output register empty, rr_ptr = 0, vc_ptr = 0, in_pkt = 0.
//   - All outputs are 0 while reset is high, including i_ready_out.
//   - Counters clear to 0.
// - Ingress handshake: i_ready_out = !full.
//   - Push on i_valid_in & i_ready_out.
//   - No push when full, even if a pop occurs in the same cycle.
// - Output register: loads from the FIFO head when it is empty or being taken (o_valid_out & o_ready_in).
//   - o_valid_out and o_data_out hold stable until o_ready_in.
// - Latency: a flit pushed in cycle N appears on o_data_out no earlier than N+2, with o_ready_in high. No bypass path.
// - Packet state machine, evaluated on each FIFO pop:
//   - IDLE, pop with sop=1: latch cur_dst = DEST[rr_ptr], cur_vc = vc_ptr; go to PKT.
//   - IDLE, pop with sop=0: flit dropped (popped, not forwarded).
//   - PKT, pop with sop=1: the previous packet is truncated and the new packet starts. Pointers advance once for the truncated packet before the new latch.
//   - Any forwarded flit with eop=1: return to IDLE.
//   - rr_ptr wraps NUM_DEST-1 -> 0; vc_ptr wraps NUM_VC-1 -> 0.
//   - Both pointers advance when the eop flit is loaded into the output register.
// - Output flit fields: head = sop, tail = eop, vc = cur_vc, dst = cur_dst; data and empty are passed unchanged.
// - Single-flit packet (sop = eop = 1): latched and released in the same pop.
// - Flit order is preserved. No flit is duplicated. Only stray flits are dropped.
// CONFIGURATION
// - PKT_STATS_EN defined:
//   - o_pkt_cnt increments when an eop flit is accepted on the output.
//   - o_drop_cnt increments once per dropped flit.
//   - Both counters saturate at all-ones.
// - PKT_STATS_EN undefined: the stats ports and counters are absent; datapath behaviour is unchanged.
// TESTING
// - Single flit, sop = eop = 1, data = {64{8'hA5}}, empty = 3, o_ready_in = 1 -> output 2 cycles later: head = tail = 1, dst = 12, vc = 0, data/empty equal.
// - Four back-to-back 3-flit packets -> dst 12, 13, 14, 15 and vc 0, 1, 0, 1; dst/vc constant within each packet; head only on flit 1, tail only on flit 3.
// - o_ready_in = 0, 10 flits offered -> 9 accepted (8 FIFO + output register), then i_ready_out = 0; release -> all 9 in order, then the 10th.
// - Stray flit sop = 0 while IDLE, then a 1-flit packet -> stray dropped, packet goes to dst = 12 (rr_ptr unchanged); o_drop_cnt = 1 if enabled.
// - Reset asserted after flit 2 of 3 -> o_valid_out = 0 and i_ready_out = 0 at once; after release the next packet gets dst = 12, vc = 0.
// - PKT_STATS_EN with 5 packets and 2 strays -> o_pkt_cnt = 5, o_drop_cnt = 2; o_drop_cnt forced to 16'hFFFF + 1 drop -> stays 16'hFFFF.

Source files
------------

// File: rtl/noc_stream_bridge.sv
// NoC endpoint bridge: unpacks flits into a FIFO and re-packs them with round-robin dst/VC.
// Optional PKT_STATS_EN macro adds forwarded-packet and dropped-flit counters.
module noc_stream_bridge #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned NOC_WIDTH  = 600,
  parameter int unsigned NUM_VC     = 2,
  parameter int unsigned NOC_RADIX  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NUM_DEST   = 4,
  parameter logic [$clog2(NOC_RADIX)-1:0] DEST [NUM_DEST] = '{4'd12, 4'd13, 4'd14, 4'd15}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NOC_WIDTH-1:0] i_data_in,
  input  logic                 i_valid_in,
  output logic                 i_ready_out,
  output logic [NOC_WIDTH-1:0] o_data_out,
  output logic                 o_valid_out,
  input  logic                 o_ready_in
`ifdef PKT_STATS_EN
  ,
  output logic [31:0]          o_pkt_cnt,
  output logic [15:0]          o_drop_cnt
`endif
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned EW    = $clog2(DATA_WIDTH / 8);
  localparam int unsigned VC_W  = $clog2(NUM_VC);
  localparam int unsigned DST_W = $clog2(NOC_RADIX);
  localparam int unsigned PL_W  = DW + 2 + EW;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned RR_W  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

  if (NOC_WIDTH < PL_W + 2 + VC_W + DST_W) begin : g_bad_layout
    $error("noc_stream_bridge: flit layout does not fit in NOC_WIDTH");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_dw
    $error("noc_stream_bridge: DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_VC < 2) begin : g_bad_vc
    $error("noc_stream_bridge: NUM_VC must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
    $error("noc_stream_bridge: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  logic [PL_W-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ready;
  logic                 r_valid;
  logic [NOC_WIDTH-1:0] r_data;
  state_t               r_state;
  logic [RR_W-1:0]      r_rr;
  logic [VC_W-1:0]      r_vc_ptr;
  logic [DST_W-1:0]     r_cur_dst;
  logic [VC_W-1:0]      r_cur_vc;

  logic                 w_push, w_pop, w_empty, w_sop, w_eop;
  logic                 w_trunc, w_fwd, w_drop;
  logic [PL_W-1:0]      w_head;
  logic [RR_W-1:0]      w_rr_base;
  logic [VC_W-1:0]      w_vc_base;
  logic [DST_W-1:0]     w_dst;
  logic [VC_W-1:0]      w_vc;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [NOC_WIDTH-1:0] w_flit;
  logic                 w_unused_hdr;

  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] p);
    return (p == RR_W'(NUM_DEST - 1)) ? '0 : p + RR_W'(1);
  endfunction

  function automatic logic [VC_W-1:0] vc_next(input logic [VC_W-1:0] p);
    return (p == VC_W'(NUM_VC - 1)) ? '0 : p + VC_W'(1);
  endfunction

  // Input header fields are discarded; only the payload is buffered.
  assign w_unused_hdr = ^i_data_in[NOC_WIDTH-1:PL_W];

  always_comb begin
    w_push      = i_valid_in & r_ready;
    w_empty     = (r_count == '0);
    w_pop       = !w_empty & (!r_valid | o_ready_in);
    w_head      = r_mem[r_rd_ptr];
    w_sop       = w_head[DW];
    w_eop       = w_head[DW+1];
    // A sop inside a packet closes the old packet before the new one latches.
    w_trunc     = w_pop & (r_state == ST_PKT) & w_sop;
    w_fwd       = w_pop & ((r_state == ST_PKT) | w_sop);
    w_drop      = w_pop & !w_fwd;
    w_rr_base   = w_trunc ? rr_next(r_rr) : r_rr;
    w_vc_base   = w_trunc ? vc_next(r_vc_ptr) : r_vc_ptr;
    w_dst       = w_sop ? DEST[w_rr_base] : r_cur_dst;
    w_vc        = w_sop ? w_vc_base : r_cur_vc;
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_flit                            = '0;
    w_flit[PL_W-1:0]                  = w_head;
    w_flit[NOC_WIDTH-1]               = w_sop;
    w_flit[NOC_WIDTH-2]               = w_eop;
    w_flit[NOC_WIDTH-3 -: VC_W]       = w_vc;
    w_flit[NOC_WIDTH-3-VC_W -: DST_W] = w_dst;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data_in[PL_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_state   <= ST_IDLE;
      r_rr      <= '0;
      r_vc_ptr  <= '0;
      r_cur_dst <= '0;
      r_cur_vc  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rr     <= (w_fwd & w_eop) ? rr_next(w_rr_base) : w_rr_base;
        r_vc_ptr <= (w_fwd & w_eop) ? vc_next(w_vc_base) : w_vc_base;
      end
      if (w_fwd) begin
        r_valid   <= 1'b1;
        r_data    <= w_flit;
        r_cur_dst <= w_dst;
        r_cur_vc  <= w_vc;
        r_state   <= w_eop ? ST_IDLE : ST_PKT;
      end else if (o_ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef PKT_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_valid && o_ready_in && r_data[DW+1] && (r_pkt_cnt != '1))
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_drop_cnt = r_drop_cnt;
`endif

  assign i_ready_out = r_ready;
  assign o_valid_out = r_valid;
  assign o_data_out  = r_data;

endmodule
